// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between requesters and the shared
// select-decoder arbiter.
interface decoder_rr_arbiter_if;
  logic       en;
  logic [7:0] req;
  logic [2:0] sel;
  logic [7:0] y_n;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output en,
    output req,
    input  sel,
    input  y_n,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  en,
    input  req,
    output sel,
    output y_n,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 active-low decoder
// among 8 requesters, with a dead cycle between grants.
module decoder_rr_arbiter #(
  parameter int HOLD_MAX = 15,
  parameter int CW       = 4
) (
  input logic                  clk,
  input logic                  rst,
  decoder_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  localparam logic [CW-1:0] LIMIT = CW'(HOLD_MAX - 1);

  state_t        state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    last_q, last_d;
  logic [7:0]    y_n_q, y_n_d;
  logic          gv_q, gv_d;
  logic          to_q, to_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [2:0]    win;
  logic          found;
  logic [2:0]    idx;
  logic          drop_a;
  logic          drop_b;
  logic          lim;

  // Search starts just past the last grantee; it comes last.
  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    idx   = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      idx = last_q + i[2:0];
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gv_d    = 1'b0;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    drop_a  = !bus.req[sel_q];
    drop_b  = !bus.en;
    lim     = (cnt_q == LIMIT);
    unique case (state_q)
      IDLE, RELEASE: begin
        if (bus.en && found) begin
          state_d = GRANT;
          sel_d   = win;
          gv_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (drop_a || drop_b || lim) begin
          state_d = RELEASE;
          last_d  = sel_q;
          to_d    = lim && !drop_a && !drop_b;
        end else begin
          gv_d  = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    y_n_d = gv_d ? ~(8'b1 << sel_d) : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      last_q  <= 3'd7;
      y_n_q   <= 8'hFF;
      gv_q    <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      y_n_q   <= y_n_d;
      gv_q    <= gv_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.y_n       = y_n_q;
  assign bus.gnt_valid = gv_q;
  assign bus.timeout   = to_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Randomized bench: three arbiters (HOLD_MAX 15, 2, 1) share
// one stimulus and are checked against a grant-level model.
module tb_decoder_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decoder_rr_arbiter_if if0 ();
  decoder_rr_arbiter_if if1 ();
  decoder_rr_arbiter_if if2 ();

  assign if0.en  = en;
  assign if0.req = req;
  assign if1.en  = en;
  assign if1.req = req;
  assign if2.en  = en;
  assign if2.req = req;

  decoder_rr_arbiter #(.HOLD_MAX(15), .CW(4)) u0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  decoder_rr_arbiter #(.HOLD_MAX(2), .CW(4)) u1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );
  decoder_rr_arbiter #(.HOLD_MAX(1), .CW(4)) u2 (
    .clk(clk), .rst(rst), .bus(if2.slave)
  );

  logic [2:0] o_sel [3];
  logic [7:0] o_yn  [3];
  logic       o_gv  [3];
  logic       o_to  [3];

  assign o_sel[0] = if0.sel;
  assign o_sel[1] = if1.sel;
  assign o_sel[2] = if2.sel;
  assign o_yn[0]  = if0.y_n;
  assign o_yn[1]  = if1.y_n;
  assign o_yn[2]  = if2.y_n;
  assign o_gv[0]  = if0.gnt_valid;
  assign o_gv[1]  = if1.gnt_valid;
  assign o_gv[2]  = if2.gnt_valid;
  assign o_to[0]  = if0.timeout;
  assign o_to[1]  = if1.timeout;
  assign o_to[2]  = if2.timeout;

  // Reference: a grant is (who, cycles shown so far); the
  // cycle after any grant is never a grant.
  int hold [3] = '{15, 2, 1};
  bit m_busy [3];
  int m_who  [3];
  int m_len  [3];
  int m_last [3];
  int m_sel  [3];
  bit m_to   [3];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int pick(int last, logic [7:0] r);
    for (int d = 1; d <= 8; d++) begin
      int c;
      c = (last + d) % 8;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model(input int k);
    bit a, b, c;
    int w;
    if (rst) begin
      m_busy[k] = 0;
      m_sel[k]  = 0;
      m_last[k] = 7;
      m_to[k]   = 0;
    end else if (m_busy[k]) begin
      a = !req[m_who[k]];
      b = !en;
      c = (m_len[k] == hold[k]);
      if (a || b || c) begin
        m_busy[k] = 0;
        m_last[k] = m_who[k];
        m_to[k]   = c && !a && !b;
      end else begin
        m_len[k]++;
        m_to[k] = 0;
      end
    end else begin
      m_to[k] = 0;
      w = pick(m_last[k], req);
      if (en && w >= 0) begin
        m_busy[k] = 1;
        m_who[k]  = w;
        m_sel[k]  = w;
        m_len[k]  = 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic e,
                      input logic [7:0] q);
    logic [7:0] eyn;
    rst = r;
    en  = e;
    req = q;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model(k);
    #1;
    for (int k = 0; k < 3; k++) begin
      eyn = m_busy[k] ? ~(8'b1 << m_sel[k]) : 8'hFF;
      chk($sformatf("y_n%0d", k), 32'(o_yn[k]), 32'(eyn));
      chk($sformatf("sel%0d", k), 32'(o_sel[k]),
          32'(m_sel[k]));
      chk($sformatf("gv%0d", k), 32'(o_gv[k]),
          32'(m_busy[k]));
      chk($sformatf("to%0d", k), 32'(o_to[k]),
          32'(m_to[k]));
    end
  endtask

  initial begin
    logic [7:0] rq;
    logic       e;
    rst = 1'b1;
    en  = 1'b1;
    req = 8'h00;
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 0;
      m_who[k]  = 0;
      m_len[k]  = 0;
      m_last[k] = 7;
      m_sel[k]  = 0;
      m_to[k]   = 0;
    end

    step(1, 1, 8'h00);
    step(1, 1, 8'h00);
    repeat (10) step(0, 1, 8'h00);

    step(0, 1, 8'h04);
    chk("single_yn", 32'(if0.y_n), 32'h0000_00FB);
    chk("single_sel", 32'(if0.sel), 32'd2);
    repeat (3) step(0, 1, 8'h04);
    repeat (3) step(0, 1, 8'h00);
    chk("single_end", 32'(if0.y_n), 32'h0000_00FF);

    repeat (30) step(0, 1, 8'hFF);
    repeat (3) step(0, 1, 8'h00);

    step(1, 1, 8'h00);
    step(0, 1, 8'h40);
    step(0, 1, 8'h40);
    step(0, 1, 8'h00);
    step(0, 1, 8'h42);
    chk("wrap_sel", 32'(if0.sel), 32'd1);
    chk("wrap_yn", 32'(if0.y_n), 32'h0000_00FD);
    repeat (4) step(0, 1, 8'h42);
    step(0, 1, 8'h40);
    step(0, 1, 8'h40);
    chk("wrap_next", 32'(if0.sel), 32'd6);
    repeat (3) step(0, 1, 8'h00);

    step(0, 1, 8'h08);
    step(0, 1, 8'h08);
    step(0, 0, 8'h08);
    chk("en_drop", 32'(if0.y_n), 32'h0000_00FF);
    step(0, 1, 8'h08);
    step(0, 1, 8'h08);
    step(1, 1, 8'h08);
    step(0, 1, 8'h80);
    chk("post_rst", 32'(if0.sel), 32'd7);
    repeat (3) step(0, 1, 8'h00);

    repeat (8) step(0, 1, 8'h01);
    repeat (2) step(0, 1, 8'h00);

    rq = 8'h00;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
      else if ($urandom_range(0, 9) == 0) rq = 8'h00;
      e = ($urandom_range(0, 15) != 0);
      step(($urandom_range(0, 99) == 0), e, rq);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
